// File: rtl/lru_set_ctrl.sv
// lru_set_ctrl
// Tag-match and replacement-state controller for one 4-way set-associative
// cache. Owns the tag, valid and used-bit arrays, resolves each lookup to a
// hit or a fill, and asks an external victim picker for a way when the
// addressed set is full.
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   req_valid/req_ready         lookup request handshake (ready = idle)
//   req_index, req_tag          set index and tag of the lookup
//   rsp_valid                   one-cycle response pulse
//   rsp_hit, rsp_way            hit flag and way hit or filled
//   rsp_evict, rsp_evict_tag    filled way held a valid line, and its tag
//   pick_valid, pick_state      victim request and the set's used vector
//   pick_done, pick_way         victim returned by the picker
//   pick_err                    pulse: returned victim had its used bit set
module lru_set_ctrl #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_index,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [1:0]       rsp_way,
    output logic             rsp_evict,
    output logic [TAG_W-1:0] rsp_evict_tag,
    output logic             pick_valid,
    output logic [3:0]       pick_state,
    input  logic             pick_done,
    input  logic [1:0]       pick_way,
    output logic             pick_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_PICK   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Lowest-numbered set bit; callers guarantee at least one bit is set.
    function automatic logic [1:0] lowest_one(input logic [3:0] v);
        logic [1:0] w;
        if (v[0])      w = 2'd0;
        else if (v[1]) w = 2'd1;
        else if (v[2]) w = 2'd2;
        else           w = 2'd3;
        return w;
    endfunction

    // Mark way w used; a vector that would become all-ones collapses to
    // just w, so a stored vector always keeps at least one zero bit.
    function automatic logic [3:0] used_update(input logic [3:0] used, input logic [1:0] w);
        logic [3:0] one_hot;
        logic [3:0] n;
        one_hot = 4'b0001 << w;
        n       = used | one_hot;
        if (n == 4'b1111) n = one_hot;
        else              n = n;
        return n;
    endfunction

    state_t           state_r;
    logic [TAG_W-1:0] tag_mem_r [SETS][4];
    logic [3:0]       valid_r   [SETS];
    logic [3:0]       used_r    [SETS];

    logic [IDX_W-1:0] idx_r;
    logic [TAG_W-1:0] tag_r;
    // LOOKUP takes two cycles: the first registers the compare results and
    // the set's state, the second acts on them.
    logic             cmp_done_r;
    logic [3:0]       match_r;
    logic [3:0]       set_valid_r;
    logic [3:0]       set_used_r;

    logic [3:0]       match_s;
    logic [1:0]       hit_way_s;
    logic [1:0]       inv_way_s;
    logic             pick_bad_s;
    logic [1:0]       fix_way_s;
    logic             lookup_fill_s;
    logic             pick_fill_s;
    logic             tag_we_s;
    logic [1:0]       tag_wway_s;

    // Tag compare, way selection and tag-array write decode.
    always_comb begin
        match_s = 4'b0000;
        for (int w = 0; w < 4; w++) begin
            match_s[w] = valid_r[idx_r][w] && (tag_mem_r[idx_r][w] == tag_r);
        end
        hit_way_s  = lowest_one(match_r);
        inv_way_s  = lowest_one(~set_valid_r);
        pick_bad_s = set_used_r[pick_way];
        if (pick_bad_s) fix_way_s = lowest_one(~set_used_r);
        else            fix_way_s = pick_way;
        lookup_fill_s = (state_r == ST_LOOKUP) && cmp_done_r &&
                        (match_r == 4'b0000) && !(&set_valid_r);
        pick_fill_s   = (state_r == ST_PICK) && pick_done;
        tag_we_s      = lookup_fill_s || pick_fill_s;
        if (pick_fill_s) tag_wway_s = fix_way_s;
        else             tag_wway_s = inv_way_s;
    end

    // Tag storage; contents are don't-care after reset, validity lives in valid_r.
    always_ff @(posedge clk) begin
        if (tag_we_s) tag_mem_r[idx_r][tag_wway_s] <= tag_r;
    end

    // Control FSM, valid/used arrays and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_hit       <= 1'b0;
            rsp_way       <= 2'd0;
            rsp_evict     <= 1'b0;
            rsp_evict_tag <= '0;
            pick_valid    <= 1'b0;
            pick_state    <= 4'b0000;
            pick_err      <= 1'b0;
            idx_r         <= '0;
            tag_r         <= '0;
            cmp_done_r    <= 1'b0;
            match_r       <= 4'b0000;
            set_valid_r   <= 4'b0000;
            set_used_r    <= 4'b0000;
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= 4'b0000;
                used_r[s]  <= 4'b0000;
            end
        end else begin
            // Response fields are pulses: zero unless set below this cycle.
            rsp_valid     <= 1'b0;
            rsp_hit       <= 1'b0;
            rsp_way       <= 2'd0;
            rsp_evict     <= 1'b0;
            rsp_evict_tag <= '0;
            pick_err      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        idx_r      <= req_index;
                        tag_r      <= req_tag;
                        cmp_done_r <= 1'b0;
                        req_ready  <= 1'b0;
                        state_r    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (!cmp_done_r) begin
                        match_r     <= match_s;
                        set_valid_r <= valid_r[idx_r];
                        set_used_r  <= used_r[idx_r];
                        cmp_done_r  <= 1'b1;
                    end else if (match_r != 4'b0000) begin
                        used_r[idx_r] <= used_update(set_used_r, hit_way_s);
                        rsp_valid     <= 1'b1;
                        rsp_hit       <= 1'b1;
                        rsp_way       <= hit_way_s;
                        state_r       <= ST_RESP;
                    end else if (lookup_fill_s) begin
                        valid_r[idx_r][inv_way_s] <= 1'b1;
                        used_r[idx_r] <= used_update(set_used_r, inv_way_s);
                        rsp_valid     <= 1'b1;
                        rsp_way       <= inv_way_s;
                        state_r       <= ST_RESP;
                    end else begin
                        pick_valid <= 1'b1;
                        pick_state <= set_used_r;
                        state_r    <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    // set_used_r still mirrors used_r[idx_r]: nothing writes
                    // the arrays while a transaction is in flight.
                    if (pick_done) begin
                        used_r[idx_r] <= used_update(set_used_r, fix_way_s);
                        rsp_valid     <= 1'b1;
                        rsp_way       <= fix_way_s;
                        rsp_evict     <= 1'b1;
                        rsp_evict_tag <= tag_mem_r[idx_r][fix_way_s];
                        pick_err      <= pick_bad_s;
                        pick_valid    <= 1'b0;
                        pick_state    <= 4'b0000;
                        state_r       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    req_ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    req_ready  <= 1'b1;
                    pick_valid <= 1'b0;
                    pick_state <= 4'b0000;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lru_set_ctrl.sv
// Self-checking bench for lru_set_ctrl: directed requests push their expected
// response (fields and arrival cycle) into a scoreboard queue; a negedge
// monitor pops and compares every rsp_valid pulse and checks that response
// fields are zero between pulses.
module tb_lru_set_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_index;
    logic [7:0] req_tag;
    logic       rsp_valid;
    logic       rsp_hit;
    logic [1:0] rsp_way;
    logic       rsp_evict;
    logic [7:0] rsp_evict_tag;
    logic       pick_valid;
    logic [3:0] pick_state;
    logic       pick_done;
    logic [1:0] pick_way;
    logic       pick_err;

    typedef struct {
        bit       hit;
        bit [1:0] way;
        bit       evict;
        bit [7:0] etag;
        bit       err;
        int       cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    lru_set_ctrl #(.SETS(16), .IDX_W(4), .TAG_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .rsp_evict(rsp_evict), .rsp_evict_tag(rsp_evict_tag),
        .pick_valid(pick_valid), .pick_state(pick_state),
        .pick_done(pick_done), .pick_way(pick_way), .pick_err(pick_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s (t=%0t)", name, detail, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_rsp", $sformatf("rsp at cycle %0d with empty scoreboard", cyc));
                end else begin
                    mon_e = sb.pop_front();
                    check((rsp_hit == mon_e.hit) && (rsp_way == mon_e.way) &&
                          (rsp_evict == mon_e.evict) && (rsp_evict_tag == mon_e.etag) &&
                          (pick_err == mon_e.err) && (cyc == mon_e.cyc),
                          "rsp",
                          $sformatf("got hit=%0d way=%0d evict=%0d etag=%h err=%0d cyc=%0d, want hit=%0d way=%0d evict=%0d etag=%h err=%0d cyc=%0d",
                                    rsp_hit, rsp_way, rsp_evict, rsp_evict_tag, pick_err, cyc,
                                    mon_e.hit, mon_e.way, mon_e.evict, mon_e.etag, mon_e.err, mon_e.cyc));
                end
            end else begin
                check(!rsp_hit && (rsp_way == 2'd0) && !rsp_evict && (rsp_evict_tag == 8'h00) && !pick_err,
                      "idle_zero",
                      $sformatf("got hit=%0d way=%0d evict=%0d etag=%h err=%0d, want all 0",
                                rsp_hit, rsp_way, rsp_evict, rsp_evict_tag, pick_err));
            end
        end
    end

    // Present a request (leaves req_valid high) and wait until it is accepted.
    task automatic issue(input logic [3:0] idx, input logic [7:0] tag,
                         input bit do_push, input bit hit, input logic [1:0] way);
        exp_t e;
        int n = 0;
        req_valid = 1'b1;
        req_index = idx;
        req_tag   = tag;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(req_ready == 1'b1, "accept", $sformatf("req_ready=%0d after %0d cycles, want 1", req_ready, n));
        if (do_push) begin
            e.hit = hit; e.way = way; e.evict = 1'b0; e.etag = 8'h00; e.err = 1'b0;
            e.cyc = cyc + 3;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) for all expected responses, then one more cycle.
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(sb.size() == 0, "rsp_timeout", $sformatf("%0d responses outstanding, want 0", sb.size()));
        sb.delete();
        @(negedge clk);
    endtask

    task automatic req(input logic [3:0] idx, input logic [7:0] tag, input bit hit, input logic [1:0] way);
        issue(idx, tag, 1'b1, hit, way);
        req_valid = 1'b0;
        drain();
    endtask

    // Full-set miss: checks the picker handshake, then answers with pw.
    task automatic pick(input logic [3:0] idx, input logic [7:0] tag, input logic [3:0] exp_state,
                        input logic [1:0] pw, input logic [1:0] exp_way, input logic [7:0] exp_etag,
                        input bit exp_err);
        exp_t e;
        issue(idx, tag, 1'b0, 1'b0, 2'd0);
        req_valid = 1'b0;
        @(negedge clk);
        check(pick_valid == 1'b0, "pick_early", $sformatf("pick_valid=%0d at T+1, want 0", pick_valid));
        @(negedge clk);
        check(pick_valid && (pick_state == exp_state), "pick_rise",
              $sformatf("pick_valid=%0d state=%b at T+2, want 1 %b", pick_valid, pick_state, exp_state));
        repeat (3) @(negedge clk);
        check(pick_valid && (pick_state == exp_state) && !rsp_valid, "pick_hold",
              $sformatf("pick_valid=%0d state=%b rsp_valid=%0d, want 1 %b 0", pick_valid, pick_state, rsp_valid, exp_state));
        pick_way  = pw;
        pick_done = 1'b1;
        e.hit = 1'b0; e.way = exp_way; e.evict = 1'b1; e.etag = exp_etag; e.err = exp_err;
        e.cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        pick_done = 1'b0;
        pick_way  = 2'd0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_index = 4'd0;
        req_tag   = 8'h00;
        pick_done = 1'b0;
        pick_way  = 2'd0;
        repeat (3) @(negedge clk);
        check(req_ready && !rsp_valid && !pick_valid && (pick_state == 4'b0000) && !pick_err && !rsp_hit &&
              (rsp_way == 2'd0) && !rsp_evict && (rsp_evict_tag == 8'h00),
              "reset_state",
              $sformatf("ready=%0d rsp_valid=%0d pick_valid=%0d state=%b err=%0d, want 1 0 0 0000 0",
                        req_ready, rsp_valid, pick_valid, pick_state, pick_err));
        reset = 1'b0;
        @(negedge clk);

        // Cold fill of set 3: ways 0..3, used ends at 1000.
        req(4'd3, 8'h10, 1'b0, 2'd0);
        req(4'd3, 8'h11, 1'b0, 2'd1);
        req(4'd3, 8'h12, 1'b0, 2'd2);
        req(4'd3, 8'h13, 1'b0, 2'd3);
        // Hits walking used: 1010, 1110, 0001, 0011, then 0111, 1000.
        req(4'd3, 8'h11, 1'b1, 2'd1);
        req(4'd3, 8'h12, 1'b1, 2'd2);
        req(4'd3, 8'h10, 1'b1, 2'd0);
        req(4'd3, 8'h11, 1'b1, 2'd1);
        req(4'd3, 8'h12, 1'b1, 2'd2);
        req(4'd3, 8'h13, 1'b1, 2'd3);
        // used: 1001, 1011, 0100, 0101.
        req(4'd3, 8'h10, 1'b1, 2'd0);
        req(4'd3, 8'h11, 1'b1, 2'd1);
        req(4'd3, 8'h12, 1'b1, 2'd2);
        req(4'd3, 8'h10, 1'b1, 2'd0);
        // Good victim: way 1 replaced (0x11 -> 0x20), used becomes 0111.
        pick(4'd3, 8'h20, 4'b0101, 2'd1, 2'd1, 8'h11, 1'b0);
        req(4'd3, 8'h20, 1'b1, 2'd1);
        // used: 1000, 1001, 1011, 0100, 0101.
        req(4'd3, 8'h13, 1'b1, 2'd3);
        req(4'd3, 8'h10, 1'b1, 2'd0);
        req(4'd3, 8'h20, 1'b1, 2'd1);
        req(4'd3, 8'h12, 1'b1, 2'd2);
        req(4'd3, 8'h10, 1'b1, 2'd0);
        // Bad victim way 0 (used): lowest zero bit is way 1, evicting 0x20.
        pick(4'd3, 8'h21, 4'b0101, 2'd0, 2'd1, 8'h20, 1'b1);
        req(4'd3, 8'h21, 1'b1, 2'd1);

        // Reset while waiting on the picker (used is 0111).
        issue(4'd3, 8'h40, 1'b0, 1'b0, 2'd0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check(pick_valid && (pick_state == 4'b0111), "pick_before_reset",
              $sformatf("pick_valid=%0d state=%b, want 1 0111", pick_valid, pick_state));
        reset = 1'b1;
        #1;
        check(!pick_valid && (pick_state == 4'b0000) && !rsp_valid && req_ready, "reset_mid_pick",
              $sformatf("pick_valid=%0d state=%b rsp_valid=%0d ready=%0d, want 0 0000 0 1",
                        pick_valid, pick_state, rsp_valid, req_ready));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        req(4'd3,  8'h10, 1'b0, 2'd0);
        req(4'd5,  8'h55, 1'b0, 2'd0);
        req(4'd0,  8'h00, 1'b0, 2'd0);
        req(4'd15, 8'hFF, 1'b0, 2'd0);

        // Back-to-back with req_valid held high; stray pick_done is ignored.
        pick_done = 1'b1;
        pick_way  = 2'd3;
        issue(4'd7, 8'h70, 1'b1, 1'b0, 2'd0);
        issue(4'd7, 8'h71, 1'b1, 1'b0, 2'd1);
        issue(4'd7, 8'h70, 1'b1, 1'b1, 2'd0);
        req_valid = 1'b0;
        pick_done = 1'b0;
        pick_way  = 2'd0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lru_set_ctrl.md
# lru_set_ctrl

Tag-match and replacement-state controller for a 4-way set-associative cache. It owns the tag, valid and per-set used-bit arrays and resolves each lookup to hit or miss. On a miss it fills an invalid way directly. When every way in the set is valid, it hands the set's used vector to the victim picker over a valid/done handshake and installs the new tag in the returned way. It is the consumer side of the picker's hit/state/replace interface.

## Interface
- SETS, 16, number of sets
- IDX_W, 4, set index width (log2 SETS)
- TAG_W, 8, tag width
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  lookup request
- req_ready  out  1  controller idle, request accepted when both high
- req_index  in  IDX_W  set index
- req_tag  in  TAG_W  tag
- rsp_valid  out  1  one-cycle response pulse
- rsp_hit  out  1  1 = hit, 0 = miss (filled)
- rsp_way  out  2  way hit or filled
- rsp_evict  out  1  filled way previously held a valid line
- rsp_evict_tag  out  TAG_W  tag of evicted line (0 if rsp_evict=0)
- pick_valid  out  1  victim request to picker
- pick_state  out  4  used vector of the set, stable while pick_valid
- pick_done  in  1  picker has a victim
- pick_way  in  2  victim way
- pick_err  out  1  one-cycle pulse: pick_way had its used bit set

## Operation
- States: IDLE, LOOKUP, PICK, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch index and tag, go to LOOKUP.
- LOOKUP: compare the latched tag against all 4 ways of the set, counting only valid ways.
  - Hit on way w: update used bits, go to RESP with hit=1.
  - Miss with any invalid way: choose the lowest-numbered invalid way, write tag, set valid, update used bits, go to RESP with hit=0 and evict=0.
  - Miss with all ways valid: go to PICK.
- PICK:
  - Hold pick_valid=1 and pick_state=used[set].
  - On pick_done, use victim v=pick_way.
  - If used[set][v]=1, pulse pick_err and use the lowest-numbered zero bit of used[set] instead.
  - Record the old tag, write the new tag, update used bits, go to RESP with evict=1.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Used-bit update for way w: n = used | (1<<w); if n==4'b1111 then n = (1<<w). The stored vector is therefore never 4'b1111, so PICK always has at least one zero bit.
- Multiple valid ways matching the tag is an illegal state; the lowest matching way wins.
- Arrays hold one entry per set: tag[SETS][4], valid[SETS][4], used[SETS] (4 bits).

## Timing
- Request accepted at edge T. LOOKUP occupies cycle T..T+1. Hit and invalid-way fills give rsp_valid high in cycle T+2..T+3.
- pick_valid rises at T+2. With pick_done sampled at edge P, rsp_valid is high in cycle P..P+1.
- pick_done is ignored outside PICK.
- No new request is accepted until the cycle after rsp_valid: req_ready=0 in LOOKUP, PICK and RESP.
- Array writes commit at the same edge the FSM leaves LOOKUP or PICK. A following request to the same set sees the updated contents.
- Reset, asynchronous:
  - All valid bits and used vectors go to 0 and the FSM goes to IDLE.
  - Outputs: req_ready=1 after release; rsp_*, pick_valid, pick_state, pick_err all 0.
  - Tag contents are don't-care.
  - Reset mid-transaction drops the request: no response and no partial array write.
- rsp_way, rsp_hit, rsp_evict and rsp_evict_tag are 0 whenever rsp_valid=0.

## Test plan
- Cold fill: after reset, request set 3 with tags 0x10, 0x11, 0x12, 0x13 → misses filled in ways 0,1,2,3, rsp_evict=0 each time, pick_valid never asserted, used[3] returns to 4'b1000 after the 4th fill.
- Hit and used reset: set 3 full with used=4'b0011; request tag 0x12 (way 2) → rsp_hit=1, rsp_way=2 at T+2, used=4'b0111. Then hit way 3 → used=4'b1000.
- Victim handshake: set 3 full with used=4'b0101; request tag 0x20 → pick_valid=1 with pick_state=4'b0101. Hold pick_done low 3 cycles, then drive it high with pick_way=1 → rsp_evict=1, rsp_evict_tag=0x11, rsp_way=1, used=4'b0111.
- Bad pick: same setup but pick_way=0 → pick_err pulses, way 1 is filled instead.
- Reset mid-PICK: assert reset while pick_valid=1 → pick_valid=0 immediately, no rsp_valid. After release, every lookup misses and fills way 0.
- Back-to-back: req_valid held high for 3 requests → each is accepted only when req_ready=1, one rsp_valid per request, in request order.
